uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side buffer sitting directly downstream of the UART receiver. It captures each completed byte on the receiver's done pulse and stores it in a circular FIFO. Bytes are presented to the CPU/bus side through a first-word-fall-through valid/ready interface. It returns a full flag that gates new frame detection in the receiver, and keeps a sticky overflow flag for dropped bytes.

Parameters:
SIZE_DATA, 8, width of one received byte
DEPTH, 16, number of FIFO entries; power of two, minimum 2
ALMOST_FULL_LVL, 12, occupancy at or above which o_almost_full asserts; range 1..DEPTH

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_rx_data  input  SIZE_DATA  parallel byte from the receiver
i_rx_done  input  1  receiver done level; may stay high for several cycles per frame
o_fifo_full  output  1  FIFO full; drives the receiver's full input
o_rd_data  output  SIZE_DATA  head-of-FIFO byte; valid while o_rd_valid=1
o_rd_valid  output  1  FIFO not empty
i_rd_ready  input  1  consumer accepts the head byte
o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
o_almost_full  output  1  o_count >= ALMOST_FULL_LVL
o_overflow  output  1  sticky: a byte arrived while the FIFO was full
i_ovf_clr  input  1  clears o_overflow

Behaviour:
- Single clock domain. Reset is synchronous, active-high, sampled on posedge i_clk.
- Reset values: all pointers and o_count = 0; o_rd_valid=0; o_fifo_full=0; o_almost_full=0 (or 1 when ALMOST_FULL_LVL=0); o_overflow=0; done-edge register=0; storage contents are don't-care.
- Done edge detect:
  - Register i_rx_done as done_q.
  - push_req = i_rx_done & ~done_q, so each frame yields exactly one push, regardless of how long done stays high.
  - i_rx_data is sampled in the push_req cycle.
- Write:
  - push = push_req & (~full | pop).
  - On push, mem[wr_ptr] <= i_rx_data and wr_ptr increments, wrapping DEPTH-1 -> 0.
- Read:
  - pop = o_rd_valid & i_rd_ready.
  - o_rd_data = mem[rd_ptr], combinational (first-word-fall-through).
  - On pop, rd_ptr increments with wrap.
  - Latency from push to o_rd_valid is 1 cycle: the byte is visible the cycle after the push cycle.
- Occupancy:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - Both or neither: count unchanged.
  - o_fifo_full = (count==DEPTH); o_rd_valid = (count!=0). Both are derived from the registered count.
- Full boundary:
  - push_req while full and no pop: byte is dropped, o_overflow <= 1, count and pointers unchanged.
  - push_req while full with simultaneous pop: both are accepted, count stays DEPTH, no overflow.
- Empty boundary:
  - i_rd_ready while empty: no pop, no pointer change.
  - Push into empty FIFO: o_rd_valid rises the next cycle; there is no same-cycle bypass.
- Overflow flag:
  - Set has priority over i_ovf_clr when both occur in the same cycle.
  - Otherwise i_ovf_clr clears it on the next edge.
- Reset mid-operation: pointers, count and flags return to reset values on the next edge; buffered bytes are discarded. A done level held through reset does not produce a push after reset release, because done_q loads i_rx_done during reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are determined from the count, not from pointer comparison.

Decomposition:
- Package uart_pkg holds SIZE_DATA default, the OVER_SAMPLE default, and a function clog2-based width helper.
- Sub-module sync_fifo: generic storage with pointers, count, full/empty and FWFT read, instantiated inside.
- Edge detect and overflow logic stay in uart_rx_fifo.

Test Plan:
- Push 0xA5 with i_rx_done high for 5 cycles, i_rd_ready=0 -> exactly one entry; o_count=1; o_rd_data=0xA5; o_rd_valid rises 1 cycle after the edge.
- Push 0x01..0x10 (16 bytes), then pop all with i_rd_ready=1 -> o_fifo_full=1 after the 16th; o_almost_full from count 12; data pops in order 0x01..0x10; o_rd_valid=0 at end.
- Fill to 16, push 0x77 with no pop -> o_overflow=1, count stays 16, 0x77 never appears. Then i_ovf_clr=1 -> o_overflow=0 the next cycle.
- Full FIFO, push 0x55 in the same cycle as pop of head 0x01 -> count stays 16, no overflow, 0x55 is read out last.
- Wrap test: 40 bytes interleaved push/pop keeping occupancy 3..5 -> all data in order, pointers wrap without loss.
- Assert i_rst with 7 entries stored and i_rx_done held high -> next cycle count=0, o_rd_valid=0. No push after release until i_rx_done falls and rises again.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_pkg;

  // Default width of one received character.
  localparam int SIZE_DATA_DEF   = 8;

  // Default receiver oversampling ratio (samples per bit period).
  localparam int OVER_SAMPLE_DEF = 16;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with first-word-fall-through read.
// Full/empty come from a registered occupancy count, never from pointer compare.
// A write is accepted when not full, or when full but a read retires the head
// in the same cycle; a read is accepted only when not empty.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = SIZE_DATA_DEF,
  parameter int DEPTH = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_req,
  input  logic [WIDTH-1:0]            i_wr_data,
  input  logic                        i_rd_req,
  output logic [WIDTH-1:0]            o_rd_data,
  output logic [cnt_width(DEPTH)-1:0] o_count,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_wr_en,
  output logic                        o_rd_en
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_wr_en;
  logic w_rd_en;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;

  // Read retires the head only when something is stored; a write into a full
  // FIFO is legal only if the head leaves in the same cycle.
  assign w_rd_en = i_rd_req & ~o_empty;
  assign w_wr_en = i_wr_req & (~o_full | w_rd_en);
  assign o_wr_en = w_wr_en;
  assign o_rd_en = w_rd_en;

  // FWFT: head entry is visible combinationally.
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; valid-ness is tracked by r_count, so
  // clearing it would only cost reset fan-out and block RAM inference.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      // NOTE: non-blocking assignments in clocked processes so every register
      // samples pre-edge values regardless of statement order.
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and occupancy update; pointers are power-of-two wide and wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: one push per rising edge of the
// done level, FWFT valid/ready read side, full/almost-full status and a
// sticky overflow flag for bytes dropped while full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int SIZE_DATA       = SIZE_DATA_DEF,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = 12
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [SIZE_DATA-1:0]        i_rx_data,
  input  logic                        i_rx_done,
  output logic                        o_fifo_full,
  output logic [SIZE_DATA-1:0]        o_rd_data,
  output logic                        o_rd_valid,
  input  logic                        i_rd_ready,
  output logic [cnt_width(DEPTH)-1:0] o_count,
  output logic                        o_almost_full,
  output logic                        o_overflow,
  input  logic                        i_ovf_clr
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] AF_CNT = CW'(ALMOST_FULL_LVL);

  logic          r_done_q;
  logic          r_overflow;
  logic          w_push_req;
  logic          w_ovf_set;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [CW-1:0] w_count;

  // Done-level history. Loaded even during reset so a level held across
  // reset release is not mistaken for a new frame.
  always_ff @(posedge i_clk) begin
    r_done_q <= i_rx_done;
  end

  assign w_push_req = i_rx_done & ~r_done_q;

  sync_fifo #(
    .WIDTH (SIZE_DATA),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_req  (w_push_req),
    .i_wr_data (i_rx_data),
    .i_rd_req  (i_rd_ready),
    .o_rd_data (o_rd_data),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_wr_en   (w_wr_en),
    .o_rd_en   (w_rd_en)
  );

  // A byte is lost only when it arrives on a full FIFO with no head leaving.
  assign w_ovf_set = w_push_req & ~w_wr_en;

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_fifo_full   = w_full;
  assign o_rd_valid    = ~w_empty;
  assign o_count       = w_count;
  assign o_almost_full = (w_count >= AF_CNT);
  assign o_overflow    = r_overflow;

endmodule : uart_rx_fifo
